// File: rtl/sample_cacher_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sample_cacher_pkg
//  Description : Shared constants, state encoding and address helper for the
//                SRAM sample ring (writer: sample_cacher, reader: FFT loader).
//  Revision    : 1.0 - initial release
// ============================================================================
package sample_cacher_pkg;

    // Address map shared by writer and FFT loader
    localparam logic [2:0] c_REGION_PREFIX = 3'b111;
    localparam logic       c_CH_L          = 1'b0;
    localparam logic       c_CH_R          = 1'b1;
    localparam int         c_SRAM_AW       = 18;

    // Default geometry
    localparam int c_BW_BUF_DEF  = 13;
    localparam int c_BW_DATA_DEF = 16;

    // Writer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR_L = 2'd1,
        ST_WR_R = 2'd2
    } state_t;

    // Build the SRAM word address of a ring entry: {0, ch, 111, index}
    function automatic logic [c_SRAM_AW-1:0] make_addr(
        input logic                    ch,
        input logic [c_BW_BUF_DEF-1:0] idx
    );
        return {1'b0, ch, c_REGION_PREFIX, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_hold_slot.sv
`default_nettype none
// ============================================================================
//  Module      : sample_hold_slot
//  Description : One-pair-deep holding register for stereo samples with a
//                full flag and a sticky overrun flag. A load in the same
//                cycle as a take is accepted (the slot is being drained).
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_hold_slot #(
    parameter int BW_DATA = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_take,
    input  logic               i_clear_overrun,
    input  logic [BW_DATA-1:0] i_l,
    input  logic [BW_DATA-1:0] i_r,
    output logic               o_full,
    output logic [BW_DATA-1:0] o_l,
    output logic [BW_DATA-1:0] o_r,
    output logic               o_overrun
);

    logic               r_full;
    logic [BW_DATA-1:0] r_l;
    logic [BW_DATA-1:0] r_r;
    logic               r_overrun;

    logic w_accept;
    logic w_drop;

    assign w_accept = i_load && (!r_full || i_take);
    assign w_drop   = i_load &&   r_full && !i_take;

    // Slot contents, occupancy and sticky overrun (set beats clear)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_full    <= 1'b0;
            r_l       <= '0;
            r_r       <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_accept) begin
                r_full <= 1'b1;
                r_l    <= i_l;
                r_r    <= i_r;
            end else if (i_take) begin
                r_full <= 1'b0;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_clear_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_full    = r_full;
    assign o_l       = r_l;
    assign o_r       = r_r;
    assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/sample_cacher.sv
`default_nettype none
// ============================================================================
//  Module      : sample_cacher
//  Description : Writes stereo sample pairs into the SRAM ring (L then R)
//                through the shared arbiter and publishes the newest ring
//                index whose L and R words are both committed.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_cacher
    import sample_cacher_pkg::*;
#(
    parameter int BW_BUF  = c_BW_BUF_DEF,
    parameter int BW_DATA = c_BW_DATA_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_enable,
    input  logic                 i_sample_valid,
    input  logic [BW_DATA-1:0]   i_sample_l,
    input  logic [BW_DATA-1:0]   i_sample_r,
    input  logic                 i_clear_overrun,
    input  logic                 i_wr_grant,
    output logic                 o_wr_req,
    output logic [c_SRAM_AW-1:0] o_wr_address,
    output logic [BW_DATA-1:0]   o_wr_data,
    output logic [BW_BUF-1:0]    o_last_write_addr,
    output logic                 o_overrun,
    output logic                 o_busy
);

    // Registered state
    state_t               r_state;
    logic                 r_wr_req;
    logic [c_SRAM_AW-1:0] r_wr_addr;
    logic [BW_DATA-1:0]   r_wr_data;
    logic [BW_DATA-1:0]   r_pend_r;      // R word of the pair in flight
    logic [BW_BUF-1:0]    r_index;
    logic [BW_BUF-1:0]    r_last;

    // Next-state values
    state_t               w_state_nxt;
    logic                 w_wr_req_nxt;
    logic [c_SRAM_AW-1:0] w_wr_addr_nxt;
    logic [BW_DATA-1:0]   w_wr_data_nxt;
    logic [BW_DATA-1:0]   w_pend_r_nxt;
    logic [BW_BUF-1:0]    w_index_nxt;
    logic [BW_BUF-1:0]    w_last_nxt;

    logic                 w_take;
    logic                 w_full;
    logic [BW_DATA-1:0]   w_hold_l;
    logic [BW_DATA-1:0]   w_hold_r;
    logic [BW_BUF-1:0]    w_index_inc;

    assign w_index_inc = r_index + {{(BW_BUF-1){1'b0}}, 1'b1};

    sample_hold_slot #(
        .BW_DATA (BW_DATA)
    ) u_hold (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_load          (i_sample_valid && i_enable),
        .i_take          (w_take),
        .i_clear_overrun (i_clear_overrun),
        .i_l             (i_sample_l),
        .i_r             (i_sample_r),
        .o_full          (w_full),
        .o_l             (w_hold_l),
        .o_r             (w_hold_r),
        .o_overrun       (o_overrun)
    );

    // State, request fields, ring index and published index
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_wr_req  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_pend_r  <= '0;
            r_index   <= '0;
            r_last    <= '1;
        end else begin
            r_state   <= w_state_nxt;
            r_wr_req  <= w_wr_req_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_pend_r  <= w_pend_r_nxt;
            r_index   <= w_index_nxt;
            r_last    <= w_last_nxt;
        end
    end

    // Next state: request fields only move on a grant or when starting a pair
    always_comb begin
        w_state_nxt   = r_state;
        w_wr_req_nxt  = r_wr_req;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_pend_r_nxt  = r_pend_r;
        w_index_nxt   = r_index;
        w_last_nxt    = r_last;
        w_take        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_full) begin
                    w_take        = 1'b1;
                    w_state_nxt   = ST_WR_L;
                    w_wr_req_nxt  = 1'b1;
                    w_wr_addr_nxt = make_addr(c_CH_L, r_index);
                    w_wr_data_nxt = w_hold_l;
                    w_pend_r_nxt  = w_hold_r;
                end
            end
            ST_WR_L: begin
                if (i_wr_grant) begin
                    w_state_nxt   = ST_WR_R;
                    w_wr_addr_nxt = make_addr(c_CH_R, r_index);
                    w_wr_data_nxt = r_pend_r;
                end
            end
            ST_WR_R: begin
                if (i_wr_grant) begin
                    // Pair fully committed: publish it and advance the ring
                    w_last_nxt  = r_index;
                    w_index_nxt = w_index_inc;
                    if (w_full) begin
                        w_take        = 1'b1;
                        w_state_nxt   = ST_WR_L;
                        w_wr_addr_nxt = make_addr(c_CH_L, w_index_inc);
                        w_wr_data_nxt = w_hold_l;
                        w_pend_r_nxt  = w_hold_r;
                    end else begin
                        w_state_nxt  = ST_IDLE;
                        w_wr_req_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_wr_req_nxt = 1'b0;
            end
        endcase
    end

    assign o_wr_req          = r_wr_req;
    assign o_wr_address      = r_wr_addr;
    assign o_wr_data         = r_wr_data;
    assign o_last_write_addr = r_last;
    assign o_busy            = (r_state != ST_IDLE) || w_full;

endmodule
`default_nettype wire
